// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-handshake signals of the fetch stage.
interface fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic [31:0] fetch_count;
    modport master (
        output pc_out, out_valid, out_instr, out_pc, out_pc_plus4, halted, fetch_count,
        input  instr_in, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  pc_out, out_valid, out_instr, out_pc, out_pc_plus4, halted, fetch_count,
        output instr_in, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and instruction fetch into a small prefetch queue feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input logic          clk,
    input logic          reset_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc_q, fetch_pc_d, fetch_count_q, fetch_count_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          halted_q, halted_d;
    logic [31:0]   ent_pc_q [DEPTH];
    logic [31:0]   ent_pc_d [DEPTH];
    logic [31:0]   ent_instr_q [DEPTH];
    logic [31:0]   ent_instr_d [DEPTH];
    logic          pop, push, redir;
    always_comb begin
        redir = bus.redirect_valid;
        pop   = (count_q != '0) & bus.out_ready;
        push  = !redir & !halted_q & ((count_q < CW'(DEPTH)) | pop);
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        if (push) begin
            ent_pc_d[wr_q]    = fetch_pc_q;
            ent_instr_d[wr_q] = bus.instr_in;
        end
        // a redirect flushes the queue but still honours a pop made in the same cycle
        rd_d          = redir ? '0 : rd_q + AW'(pop);
        wr_d          = redir ? '0 : wr_q + AW'(push);
        count_d       = redir ? '0 : count_q + CW'(push) - CW'(pop);
        fetch_pc_d    = redir ? (bus.redirect_pc & ~32'd3) : fetch_pc_q + (push ? 32'd4 : 32'd0);
        fetch_count_d = fetch_count_q + 32'(push);
        halted_d      = redir ? 1'b0 : halted_q | (push & (bus.instr_in == HALT_INSTR));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            fetch_count_q <= '0;
            count_q       <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            halted_q      <= 1'b0;
            ent_pc_q      <= '{default: '0};
            ent_instr_q   <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            count_q       <= count_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            halted_q      <= halted_d;
            ent_pc_q      <= ent_pc_d;
            ent_instr_q   <= ent_instr_d;
        end
    end
    assign bus.pc_out       = fetch_pc_q;
    assign bus.out_valid    = (count_q != '0);
    assign bus.out_instr    = ent_instr_q[rd_q];
    assign bus.out_pc       = ent_pc_q[rd_q];
    assign bus.out_pc_plus4 = ent_pc_q[rd_q] + 32'd4;
    assign bus.halted       = halted_q;
    assign bus.fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, redirect, halt, async reset and PC wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset_n;
    logic halt_en;
    int   tests = 0;
    int   fails = 0;
    fetch_unit_if bus ();
    fetch_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction
    assign bus.instr_in = (halt_en && bus.pc_out == 32'h0040_0010) ? 32'h0000_000C : mem(bus.pc_out);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask
    initial begin
        reset_n = 1'b0;
        halt_en = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_plus4", bus.out_pc_plus4, 4);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_count", bus.fetch_count, 0);
        chk("rst_pc_out", bus.pc_out, 32'h0040_0000);
        reset_n = 1'b1;
        // test 1: streaming
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_a", bus.out_instr, mem(32'h0040_0000));
        chk("t1_a_pc", bus.out_pc, 32'h0040_0000);
        chk("t1_a_p4", bus.out_pc_plus4, 32'h0040_0004);
        @(negedge clk);
        chk("t1_b", bus.out_instr, mem(32'h0040_0004));
        @(negedge clk);
        chk("t1_c", bus.out_instr, mem(32'h0040_0008));
        chk("t1_cnt", bus.fetch_count, 3);
        // test 2: backpressure
        bus.out_ready = 1'b0;
        pulse_reset();
        @(negedge clk);
        chk("t2_pc1", bus.pc_out, 32'h0040_0004);
        @(negedge clk);
        chk("t2_pc2", bus.pc_out, 32'h0040_0008);
        @(negedge clk);
        chk("t2_hold_pc", bus.pc_out, 32'h0040_0008);
        chk("t2_hold_a", bus.out_instr, mem(32'h0040_0000));
        chk("t2_hold_cnt", bus.fetch_count, 2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_b", bus.out_instr, mem(32'h0040_0004));
        chk("t2_pc3", bus.pc_out, 32'h0040_000C);
        @(negedge clk);
        chk("t2_c", bus.out_instr, mem(32'h0040_0008));
        // test 3: redirect with full queue
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0043;
        @(negedge clk);
        chk("t3_pc", bus.pc_out, 32'h0040_0040);
        chk("t3_bubble", 32'(bus.out_valid), 0);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_valid", 32'(bus.out_valid), 1);
        chk("t3_out_pc", bus.out_pc, 32'h0040_0040);
        chk("t3_instr", bus.out_instr, mem(32'h0040_0040));
        chk("t3_cnt", bus.fetch_count, 5);
        // test 4: halt on syscall
        halt_en = 1'b1;
        pulse_reset();
        repeat (5) @(negedge clk);
        chk("t4_halted", 32'(bus.halted), 1);
        chk("t4_sys", bus.out_instr, 32'h0000_000C);
        chk("t4_sys_pc", bus.out_pc, 32'h0040_0010);
        chk("t4_pc", bus.pc_out, 32'h0040_0014);
        chk("t4_cnt", bus.fetch_count, 5);
        repeat (2) @(negedge clk);
        chk("t4_drained", 32'(bus.out_valid), 0);
        chk("t4_pc_frz", bus.pc_out, 32'h0040_0014);
        chk("t4_cnt_frz", bus.fetch_count, 5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0000;
        @(negedge clk);
        chk("t4_unhalt", 32'(bus.halted), 0);
        chk("t4_re_pc", bus.pc_out, 32'h0040_0000);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_resume", bus.out_instr, mem(32'h0040_0000));
        chk("t4_re_cnt", bus.fetch_count, 6);
        // test 5: async reset between edges
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_pre", 32'(bus.out_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_valid", 32'(bus.out_valid), 0);
        chk("t5_pc", bus.pc_out, 32'h0040_0000);
        chk("t5_cnt", bus.fetch_count, 0);
        reset_n = 1'b1;
        // test 6: PC wrap
        halt_en = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("t6_pc", bus.pc_out, 32'hFFFF_FFFC);
        chk("t6_bubble", 32'(bus.out_valid), 0);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_wrap", bus.pc_out, 32'h0000_0000);
        chk("t6_out_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("t6_p4", bus.out_pc_plus4, 32'h0000_0000);
        chk("t6_instr", bus.out_instr, mem(32'hFFFF_FFFC));
        @(negedge clk);
        chk("t6_next_pc", bus.out_pc, 32'h0000_0000);
        chk("t6_next_p4", bus.out_pc_plus4, 32'h0000_0004);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
